// File: rtl/nfc_page_buffer.sv
`default_nettype none
// ============================================================================
// Module   : nfc_page_buffer
// Purpose  : Page staging buffer shared by the host interface and the NAND
//            memory controller. One side fills a page and the other side
//            drains it. The buffer has a single storage array, shared
//            write/read pointers, an occupancy count and sticky error flags.
// Ports    : clk, Reset (async, active-low), buf_clr (sync clear)
//            host_we/host_din, host_re -> host_dout/host_dvalid
//            nfc_we/nfc_din,   nfc_re  -> nfc_dout/nfc_dvalid
//            word_count, buf_full, buf_empty, page_done,
//            err_ovf, err_unf, err_col
// Revision : 1.0 - initial release
// ============================================================================
module nfc_page_buffer #(
    parameter int DataWidth = 16,
    parameter int PageWords = 2048,
    parameter int AddrWidth = 11
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 buf_clr,
    input  logic                 host_we,
    input  logic [DataWidth-1:0] host_din,
    input  logic                 host_re,
    output logic [DataWidth-1:0] host_dout,
    output logic                 host_dvalid,
    input  logic                 nfc_we,
    input  logic [DataWidth-1:0] nfc_din,
    input  logic                 nfc_re,
    output logic [DataWidth-1:0] nfc_dout,
    output logic                 nfc_dvalid,
    output logic [AddrWidth:0]   word_count,
    output logic                 buf_full,
    output logic                 buf_empty,
    output logic                 page_done,
    output logic                 err_ovf,
    output logic                 err_unf,
    output logic                 err_col
);

    localparam logic [AddrWidth:0] c_full_count = (AddrWidth+1)'(PageWords);
    localparam logic [AddrWidth:0] c_last_count = (AddrWidth+1)'(PageWords - 1);

    // Storage array; contents are deliberately not reset.
    logic [DataWidth-1:0] mem [PageWords];

    logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrWidth:0]   count_q, count_d;
    logic [DataWidth-1:0] host_dout_q, host_dout_d;
    logic [DataWidth-1:0] nfc_dout_q, nfc_dout_d;
    logic                 host_dvalid_q, host_dvalid_d;
    logic                 nfc_dvalid_q, nfc_dvalid_d;
    logic                 page_done_q, page_done_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 err_unf_q, err_unf_d;
    logic                 err_col_q, err_col_d;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_req;
    logic                 w_rd_req;
    logic                 w_col;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic [DataWidth-1:0] w_wr_data;
    logic [DataWidth-1:0] w_rd_data;

    assign w_full    = (count_q == c_full_count);
    assign w_empty   = (count_q == '0);
    // XOR: exactly one requester; both at once is a collision and is ignored.
    assign w_wr_req  = host_we ^ nfc_we;
    assign w_rd_req  = host_re ^ nfc_re;
    assign w_col     = (host_we & nfc_we) | (host_re & nfc_re);
    // Full/empty come from the registered count, so at full a same-cycle
    // read wins over the write and at empty the write wins over the read
    // (no bypass of the just-written word).
    assign w_wr_acc  = w_wr_req & ~w_full & ~buf_clr;
    assign w_rd_acc  = w_rd_req & ~w_empty & ~buf_clr;
    assign w_wr_data = host_we ? host_din : nfc_din;
    assign w_rd_data = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        host_dout_d   = host_dout_q;
        nfc_dout_d    = nfc_dout_q;
        host_dvalid_d = 1'b0;
        nfc_dvalid_d  = 1'b0;
        page_done_d   = 1'b0;
        err_ovf_d     = err_ovf_q;
        err_unf_d     = err_unf_q;
        err_col_d     = err_col_q;

        if (buf_clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            host_dout_d = '0;
            nfc_dout_d  = '0;
            err_ovf_d   = 1'b0;
            err_unf_d   = 1'b0;
            err_col_d   = 1'b0;
        end else begin
            if (w_wr_acc) begin
                // Power-of-two depth: natural overflow wraps the pointer.
                wr_ptr_d = wr_ptr_q + AddrWidth'(1);
            end
            if (w_rd_acc) begin
                rd_ptr_d = rd_ptr_q + AddrWidth'(1);
                if (host_re) begin
                    host_dout_d   = w_rd_data;
                    host_dvalid_d = 1'b1;
                end else begin
                    nfc_dout_d    = w_rd_data;
                    nfc_dvalid_d  = 1'b1;
                end
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   count_d = count_q + (AddrWidth+1)'(1);
                2'b01:   count_d = count_q - (AddrWidth+1)'(1);
                default: count_d = count_q;
            endcase
            page_done_d = w_wr_acc & ~w_rd_acc & (count_q == c_last_count);
            if (w_wr_req & w_full) begin
                err_ovf_d = 1'b1;
            end
            if (w_rd_req & w_empty) begin
                err_unf_d = 1'b1;
            end
            if (w_col) begin
                err_col_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            host_dout_q   <= '0;
            nfc_dout_q    <= '0;
            host_dvalid_q <= 1'b0;
            nfc_dvalid_q  <= 1'b0;
            page_done_q   <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_unf_q     <= 1'b0;
            err_col_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            host_dout_q   <= host_dout_d;
            nfc_dout_q    <= nfc_dout_d;
            host_dvalid_q <= host_dvalid_d;
            nfc_dvalid_q  <= nfc_dvalid_d;
            page_done_q   <= page_done_d;
            err_ovf_q     <= err_ovf_d;
            err_unf_q     <= err_unf_d;
            err_col_q     <= err_col_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem[wr_ptr_q] <= w_wr_data;
        end
    end

    assign host_dout   = host_dout_q;
    assign host_dvalid = host_dvalid_q;
    assign nfc_dout    = nfc_dout_q;
    assign nfc_dvalid  = nfc_dvalid_q;
    assign word_count  = count_q;
    assign buf_full    = w_full;
    assign buf_empty   = w_empty;
    assign page_done   = page_done_q;
    assign err_ovf     = err_ovf_q;
    assign err_unf     = err_unf_q;
    assign err_col     = err_col_q;

endmodule
`default_nettype wire

// File: tb/tb_nfc_page_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nfc_page_buffer
// Purpose  : Directed self-checking bench for nfc_page_buffer. A queue model
//            of the buffer predicts accepted reads; expected read data is
//            pushed to per-side scoreboards and popped on each dvalid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nfc_page_buffer;

    localparam int DW = 16;
    localparam int PW = 2048;
    localparam int AW = 11;

    logic          clk      = 1'b0;
    logic          Reset    = 1'b0;
    logic          buf_clr  = 1'b0;
    logic          host_we  = 1'b0;
    logic [DW-1:0] host_din = '0;
    logic          host_re  = 1'b0;
    logic          nfc_we   = 1'b0;
    logic [DW-1:0] nfc_din  = '0;
    logic          nfc_re   = 1'b0;
    logic [DW-1:0] host_dout;
    logic          host_dvalid;
    logic [DW-1:0] nfc_dout;
    logic          nfc_dvalid;
    logic [AW:0]   word_count;
    logic          buf_full;
    logic          buf_empty;
    logic          page_done;
    logic          err_ovf;
    logic          err_unf;
    logic          err_col;

    nfc_page_buffer #(
        .DataWidth (DW),
        .PageWords (PW),
        .AddrWidth (AW)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .buf_clr     (buf_clr),
        .host_we     (host_we),
        .host_din    (host_din),
        .host_re     (host_re),
        .host_dout   (host_dout),
        .host_dvalid (host_dvalid),
        .nfc_we      (nfc_we),
        .nfc_din     (nfc_din),
        .nfc_re      (nfc_re),
        .nfc_dout    (nfc_dout),
        .nfc_dvalid  (nfc_dvalid),
        .word_count  (word_count),
        .buf_full    (buf_full),
        .buf_empty   (buf_empty),
        .page_done   (page_done),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf),
        .err_col     (err_col)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] mdl [$];
    logic [DW-1:0] hq  [$];
    logic [DW-1:0] nq  [$];
    logic [DW-1:0] last_h = '0;
    logic [DW-1:0] last_n = '0;
    logic          e_ovf  = 1'b0;
    logic          e_unf  = 1'b0;
    logic          e_col  = 1'b0;
    int            hv_count = 0;
    int            pd_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl.delete();
        hq.delete();
        nq.delete();
        last_h = '0;
        last_n = '0;
        e_ovf  = 1'b0;
        e_unf  = 1'b0;
        e_col  = 1'b0;
    endtask

    task automatic chk_status(input logic exp_hv, input logic exp_nv, input logic exp_pd);
        chk("host_dvalid", 32'(host_dvalid), 32'(exp_hv));
        if (host_dvalid) begin
            if (hq.size() == 0) chk("host_dvalid_unexpected", 32'(1), 32'(0));
            else last_h = hq.pop_front();
        end
        chk("host_dout", 32'(host_dout), 32'(last_h));
        chk("nfc_dvalid", 32'(nfc_dvalid), 32'(exp_nv));
        if (nfc_dvalid) begin
            if (nq.size() == 0) chk("nfc_dvalid_unexpected", 32'(1), 32'(0));
            else last_n = nq.pop_front();
        end
        chk("nfc_dout", 32'(nfc_dout), 32'(last_n));
        chk("word_count", 32'(word_count), 32'(mdl.size()));
        chk("buf_full", 32'(buf_full), 32'(mdl.size() == PW));
        chk("buf_empty", 32'(buf_empty), 32'(mdl.size() == 0));
        chk("page_done", 32'(page_done), 32'(exp_pd));
        chk("err_ovf", 32'(err_ovf), 32'(e_ovf));
        chk("err_unf", 32'(err_unf), 32'(e_unf));
        chk("err_col", 32'(err_col), 32'(e_col));
    endtask

    // One clock cycle: predict, drive, clock, then check 1 time unit later.
    task automatic step(input logic hwe, input logic [DW-1:0] hd, input logic hre,
                        input logic nwe, input logic [DW-1:0] nd, input logic nre,
                        input logic clr);
        logic full, empty, wreq, rreq, wacc, racc, exp_hv, exp_nv, exp_pd;
        full   = (mdl.size() == PW);
        empty  = (mdl.size() == 0);
        wreq   = hwe ^ nwe;
        rreq   = hre ^ nre;
        exp_hv = 1'b0;
        exp_nv = 1'b0;
        exp_pd = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            wacc = wreq & !full;
            racc = rreq & !empty;
            if ((hwe & nwe) | (hre & nre)) e_col = 1'b1;
            if (wreq & full)  e_ovf = 1'b1;
            if (rreq & empty) e_unf = 1'b1;
            if (racc) begin
                if (hre) begin
                    hq.push_back(mdl[0]);
                    exp_hv = 1'b1;
                end else begin
                    nq.push_back(mdl[0]);
                    exp_nv = 1'b1;
                end
                void'(mdl.pop_front());
            end
            if (wacc) begin
                mdl.push_back(hwe ? hd : nd);
                if (!racc && mdl.size() == PW) exp_pd = 1'b1;
            end
        end
        host_we  = hwe;
        host_din = hd;
        host_re  = hre;
        nfc_we   = nwe;
        nfc_din  = nd;
        nfc_re   = nre;
        buf_clr  = clr;
        @(posedge clk);
        #1;
        host_we  = 1'b0;
        host_re  = 1'b0;
        nfc_we   = 1'b0;
        nfc_re   = 1'b0;
        buf_clr  = 1'b0;
        if (host_dvalid) hv_count++;
        if (page_done)   pd_count++;
        chk_status(exp_hv, exp_nv, exp_pd);
    endtask

    initial begin
        // Reset state
        #12;
        chk_status(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        Reset = 1'b1;

        // Reset mid-fill
        for (int i = 0; i < 100; i++) step(1, 16'(i), 0, 0, 0, 0, 0);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        chk_status(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        Reset = 1'b1;
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Program path
        pd_count = 0;
        for (int i = 0; i < PW; i++) step(1, 16'(16'h0030 + i), 0, 0, 0, 0, 0);
        chk("program_page_done_pulses", 32'(pd_count), 32'(1));
        for (int i = 0; i < PW; i++) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Read path
        for (int i = 0; i < PW; i++) step(0, 0, 0, 1, 16'(16'hA000 + i), 0, 0);
        hv_count = 0;
        for (int i = 0; i < PW; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("read_path_dvalid_cycles", 32'(hv_count), 32'(PW));

        // Overflow / underflow
        for (int i = 0; i < PW; i++) step(1, 16'(i ^ 16'h5A5A), 0, 0, 0, 0, 0);
        step(1, 16'hDEAD, 0, 0, 0, 0, 0);
        step(1, 16'hBEEF, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 16'h1234, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Simultaneous write and read
        for (int i = 0; i < 10; i++) step(1, 16'(16'h0100 + i), 0, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) step(1, 16'(16'h0200 + i), 0, 0, 0, 1, 0);
        step(1, 16'h1111, 0, 1, 16'h2222, 0, 0);
        step(0, 0, 1, 1, 16'h3333, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Pointer wrap
        for (int i = 0; i < PW; i++) step(1, 16'($urandom), 0, 0, 0, 0, 0);
        for (int i = 0; i < PW / 2; i++) step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < PW / 2; i++) step(0, 0, 0, 1, 16'($urandom), 0, 0);
        for (int i = 0; i < PW; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", 32'(hq.size() + nq.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
